bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 The block SHALL have parameter NB_BITS, default 16, meaning instruction/data word width.
REQ-002 The block SHALL have parameter NB_ADDR, default 11, meaning program/data address and operand width.
REQ-003 The block SHALL have parameter NB_OPCODE, default 5, meaning opcode width (NB_BITS = NB_OPCODE + NB_ADDR).
REQ-004 The block SHALL have parameter NB_CYC, default 32, meaning cycle counter width.
REQ-005 The block SHALL have ports, clock and reset first:
- i_clk, input, 1: clock, all state updates on rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_start, input, 1: start program execution; sampled in IDLE only.
- i_instr, input, NB_BITS: program memory read data; synchronous read, valid the cycle after o_pc is presented.
- o_pc, output, NB_ADDR: program memory address.
- o_operand, output, NB_ADDR: immediate/operand to datapath, IR[NB_ADDR-1:0].
- o_data_addr, output, NB_ADDR: data memory address.
- o_rd_ram, output, 1: data memory read enable.
- o_wr_ram, output, 1: data memory write enable; write data is the accumulator.
- o_sel_a, output, 2: accumulator source (00 memory, 01 sign-extended operand, 10 ALU result).
- o_sel_b, output, 1: ALU B operand (0 memory, 1 sign-extended operand).
- o_op_code, output, 1: ALU operation (1 add, 0 subtract).
- o_wr_acc, output, 1: accumulator write enable.
- o_halt, output, 1: processor halted.
- o_cycles, output, NB_CYC: active clock cycle count.

Function
REQ-006 The block SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-007 Transitions SHALL be: IDLE->FETCH when i_start=1 (else stay); FETCH->DECODE; DECODE->EXEC; EXEC->HALT if IR opcode is HLT, else EXEC->FETCH; HALT->HALT until reset.
REQ-008 Each non-HLT instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC).
REQ-009 In FETCH, o_pc SHALL hold PC; no enables asserted.
REQ-010 In DECODE, IR SHALL be loaded from i_instr at the closing edge; o_data_addr SHALL equal i_instr[NB_ADDR-1:0] and o_rd_ram SHALL be 1 iff i_instr opcode is LD, ADD or SUB.
REQ-011 In EXEC, o_data_addr SHALL equal IR operand and o_operand SHALL equal IR operand.
REQ-012 Opcode decode in EXEC:
- 00000 HLT: no enables.
- 00001 STO: o_wr_ram=1.
- 00010 LD: o_wr_acc=1, o_sel_a=00.
- 00011 LDI: o_wr_acc=1, o_sel_a=01.
- 00100 ADD: o_wr_acc=1, o_sel_a=10, o_sel_b=0, o_op_code=1.
- 00101 ADDI: as ADD with o_sel_b=1.
- 00110 SUB: o_wr_acc=1, o_sel_a=10, o_sel_b=0, o_op_code=0.
- 00111 SUBI: as SUB with o_sel_b=1.
- 01000-11111: NOP, no enables, PC advances.
REQ-013 o_wr_acc, o_wr_ram SHALL be 1 only in EXEC; o_rd_ram only in DECODE; o_sel_a, o_sel_b, o_op_code SHALL be 0 outside EXEC.
REQ-014 PC SHALL increment by 1 at the EXEC->FETCH edge only, modulo 2^NB_ADDR (max address wraps to 0).
REQ-015 On HLT, PC SHALL retain the HLT address; o_halt SHALL be 1 from the first HALT cycle onward.
REQ-016 o_cycles SHALL increment by 1 on each cycle spent in FETCH, DECODE or EXEC, saturate at all-ones, and hold in IDLE and HALT.
REQ-017 i_start SHALL be ignored in every state except IDLE.
REQ-018 All outputs SHALL be registered or decoded solely from state/IR/i_instr; no combinational path from i_start to any output.

Reset
REQ-019 i_rst=1 SHALL, at the next rising edge and regardless of state, force IDLE, PC=0, IR=0, o_cycles=0, o_halt=0, all enables and selects 0.
REQ-020 Reset asserted mid-instruction SHALL suppress that instruction's o_wr_acc/o_wr_ram in the following cycle.

Verification
REQ-021 Program {LDI 5, ADDI -1, HLT}, i_start pulse -> o_wr_acc in cycles 3 and 6 with o_sel_a 01 then 10, o_sel_b=1, o_op_code=1; o_halt=1 after 9 active cycles; o_cycles=9; PC=2.
REQ-022 Program {LD 7, SUB 8, STO 9, HLT} -> o_rd_ram in DECODE with o_data_addr 7 then 8; o_wr_ram=1 with o_data_addr=9 in EXEC of instruction 3; o_cycles=12.
REQ-023 Opcode 11111 at PC 0 followed by HLT -> no enables for the first instruction; halt at PC=1.
REQ-024 PC preset to 2^NB_ADDR-1 via NOP-filled memory -> next FETCH presents o_pc=0.
REQ-025 i_rst during EXEC of LDI -> no o_wr_acc the following cycle; state IDLE, o_pc=0, o_cycles=0; i_start while in FETCH is ignored.

Source files
------------

// File: rtl/bip_control.sv
// bip_control: fetch/decode/execute sequencer for the BIP accumulator processor
module bip_control #(
  parameter int NB_BITS   = 16,
  parameter int NB_ADDR   = 11,
  parameter int NB_OPCODE = 5,
  parameter int NB_CYC    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_instr,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_operand,
  output logic [NB_ADDR-1:0] o_data_addr,
  output logic               o_rd_ram,
  output logic               o_wr_ram,
  output logic [1:0]         o_sel_a,
  output logic               o_sel_b,
  output logic               o_op_code,
  output logic               o_wr_acc,
  output logic               o_halt,
  output logic [NB_CYC-1:0]  o_cycles
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [NB_OPCODE-1:0] OP_HLT = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD  = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_SUB = 5'b00110;
  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   pc_q, pc_d;
  logic [NB_BITS-1:0]   ir_q, ir_d;
  logic [NB_CYC-1:0]    cycles_q, cycles_d;
  logic [NB_OPCODE-1:0] ir_op, in_op;
  logic                 dec, exe, alu, active;
  assign ir_op  = ir_q[NB_BITS-1:NB_ADDR];
  assign in_op  = i_instr[NB_BITS-1:NB_ADDR];
  assign dec    = state_q == DECODE;
  assign exe    = state_q == EXEC;
  assign active = state_q == FETCH || dec || exe;
  assign alu    = exe && ir_op[NB_OPCODE-1:2] == 3'b001;
  // State, PC, IR and cycle counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cycles_q <= cycles_d;
    end
  end
  // Next-state sequencing: PC only moves when a non-halt instruction retires
  always_comb begin
    state_d  = state_q == IDLE   ? (i_start ? FETCH : IDLE) :
               state_q == FETCH  ? DECODE :
               dec               ? EXEC :
               exe               ? (ir_op == OP_HLT ? HALT : FETCH) : state_q;
    pc_d     = (exe && ir_op != OP_HLT) ? pc_q + NB_ADDR'(1) : pc_q;
    ir_d     = dec ? i_instr : ir_q;
    cycles_d = (active && ~&cycles_q) ? cycles_q + NB_CYC'(1) : cycles_q;
  end
  // Datapath controls decoded from state, IR and (in DECODE) the incoming word
  always_comb begin
    o_pc        = pc_q;
    o_operand   = ir_q[NB_ADDR-1:0];
    o_data_addr = dec ? i_instr[NB_ADDR-1:0] : exe ? ir_q[NB_ADDR-1:0] : '0;
    o_rd_ram    = dec && (in_op == OP_LD || in_op == OP_ADD || in_op == OP_SUB);
    o_wr_ram    = exe && ir_op == OP_STO;
    o_wr_acc    = alu || (exe && (ir_op == OP_LD || ir_op == OP_LDI));
    o_sel_a     = alu ? 2'b10 : (exe && ir_op == OP_LDI) ? 2'b01 : 2'b00;
    o_sel_b     = alu && ir_op[0];
    o_op_code   = alu && !ir_op[1];
    o_halt      = state_q == HALT;
    o_cycles    = cycles_q;
  end
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed checks of the BIP control sequencer
module tb_bip_control;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] instr = '0;
  logic [10:0] pc, operand, data_addr;
  logic        rd_ram, wr_ram, sel_b, op_code, wr_acc, halt;
  logic [1:0]  sel_a;
  logic [31:0] cycles;
  logic [15:0] mem [2048];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [6:0]  en;

  bip_control dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_instr(instr),
    .o_pc(pc), .o_operand(operand), .o_data_addr(data_addr),
    .o_rd_ram(rd_ram), .o_wr_ram(wr_ram), .o_sel_a(sel_a), .o_sel_b(sel_b),
    .o_op_code(op_code), .o_wr_acc(wr_acc), .o_halt(halt), .o_cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= mem[pc];

  assign en = {rd_ram, wr_ram, wr_acc, sel_a, sel_b, op_code};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    step(1);
    rst = 0;
  endtask

  task automatic do_start();
    start = 1;
    step(1);
    start = 0;
  endtask

  task automatic clear_mem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) mem[i] = fill;
  endtask

  initial begin
    clear_mem(16'h0000);
    step(2);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_en", 32'(en), 0);
    rst = 0;
    step(3);
    chk("idle_cycles_hold", cycles, 0);

    // LDI 5, ADDI -1, HLT
    mem[0] = 16'h1805; mem[1] = 16'h2FFF; mem[2] = 16'h0000;
    do_start();
    chk("p1_c1_pc", 32'(pc), 0);
    chk("p1_c1_en", 32'(en), 0);
    step(1);
    chk("p1_c2_en", 32'(en), 0);
    step(1);
    chk("p1_c3_ldi", 32'(en), 32'h14);
    chk("p1_c3_operand", 32'(operand), 5);
    step(1);
    chk("p1_c4_pc", 32'(pc), 1);
    step(2);
    chk("p1_c6_addi", 32'(en), 32'h1B);
    chk("p1_c6_operand", 32'(operand), 32'h7FF);
    step(3);
    chk("p1_c9_en", 32'(en), 0);
    chk("p1_c9_halt", 32'(halt), 0);
    step(1);
    chk("p1_halt", 32'(halt), 1);
    chk("p1_cycles", cycles, 9);
    chk("p1_pc", 32'(pc), 2);
    start = 1;
    step(2);
    start = 0;
    step(1);
    chk("p1_halt_start_ign", 32'(halt), 1);
    chk("p1_halt_cycles", cycles, 9);

    // LD 7, SUB 8, STO 9, HLT
    do_reset();
    chk("p2_rst_halt", 32'(halt), 0);
    chk("p2_rst_cycles", cycles, 0);
    mem[0] = 16'h1007; mem[1] = 16'h3008; mem[2] = 16'h0809; mem[3] = 16'h0000;
    do_start();
    step(1);
    chk("p2_c2_rd", 32'(en), 32'h40);
    chk("p2_c2_addr", 32'(data_addr), 7);
    step(1);
    chk("p2_c3_ld", 32'(en), 32'h10);
    step(2);
    chk("p2_c5_rd", 32'(en), 32'h40);
    chk("p2_c5_addr", 32'(data_addr), 8);
    step(1);
    chk("p2_c6_sub", 32'(en), 32'h18);
    step(2);
    chk("p2_c8_en", 32'(en), 0);
    step(1);
    chk("p2_c9_sto", 32'(en), 32'h20);
    chk("p2_c9_addr", 32'(data_addr), 9);
    step(4);
    chk("p2_halt", 32'(halt), 1);
    chk("p2_cycles", cycles, 12);
    chk("p2_pc", 32'(pc), 3);

    // opcode 11111 then HLT
    do_reset();
    mem[0] = 16'hF800; mem[1] = 16'h0000;
    do_start();
    step(1);
    chk("p3_c2_en", 32'(en), 0);
    step(1);
    chk("p3_c3_en", 32'(en), 0);
    step(4);
    chk("p3_halt", 32'(halt), 1);
    chk("p3_pc", 32'(pc), 1);

    // reset during EXEC of LDI; start during FETCH ignored
    do_reset();
    mem[0] = 16'h1805; mem[1] = 16'h2FFF; mem[2] = 16'h0000;
    do_start();
    start = 1;
    step(1);
    start = 0;
    step(1);
    chk("p5_c3_ldi", 32'(en), 32'h14);
    rst = 1;
    step(1);
    chk("p5_rst_en", 32'(en), 0);
    chk("p5_rst_pc", 32'(pc), 0);
    chk("p5_rst_cycles", cycles, 0);
    chk("p5_rst_halt", 32'(halt), 0);
    rst = 0;
    step(3);
    chk("p5_idle_cycles", cycles, 0);

    // NOP-filled memory: PC wraps from 2047 to 0
    do_reset();
    clear_mem(16'h4000);
    do_start();
    step(6141);
    chk("p4_pc_max", 32'(pc), 2047);
    step(2);
    chk("p4_nop_en", 32'(en), 0);
    step(1);
    chk("p4_pc_wrap", 32'(pc), 0);
    chk("p4_cycles", cycles, 6144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
